// File: rtl/mdio_master_if.sv
// Request/completion bus between the management requesters and mdio_master.
// Two requesters share the bus; per-requester fields are packed side by side,
// requester i owning req[i], req_phy[5i+4:5i], req_reg[5i+4:5i] and
// req_wdata[16i+15:16i].
//   master modport: requester side (drives req*, observes ack/done/results)
//   slave modport : controller side (mdio_master)
interface mdio_master_if;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [9:0]  req_phy;
  logic [9:0]  req_reg;
  logic [31:0] req_wdata;
  logic [1:0]  ack;
  logic        done;
  logic        done_id;
  logic [15:0] rdata;
  logic        rd_err;
  logic        busy;

  modport master (
    output req, req_wr, req_phy, req_reg, req_wdata,
    input  ack, done, done_id, rdata, rd_err, busy
  );

  modport slave (
    input  req, req_wr, req_phy, req_reg, req_wdata,
    output ack, done, done_id, rdata, rd_err, busy
  );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master shared by two requesters with round-robin arbitration.
// A granted request is serialised MSB first onto mdc/mdio_o/mdio_oe; read data
// and the turnaround error flag are returned with a one-cycle done pulse.
// Ports:
//   clk_200_mhz       system clock
//   rst               synchronous active-high reset
//   bus (slave)       request fields, ack, done/done_id, rdata, rd_err, busy
//   mdc               management clock (MDC_DIV clk cycles per half-period)
//   mdio_o, mdio_oe   MDIO drive data / enable (to an IOBUF)
//   mdio_i            MDIO input data
// Build option: define MDIO_SHORT_PREAMBLE_EN to drop the 32-bit preamble
// (32-bit frames, only for PHYs supporting preamble suppression).
module mdio_master #(
  parameter int unsigned MDC_DIV = 40
) (
  input  logic          clk_200_mhz,
  input  logic          rst,
  mdio_master_if.slave  bus,
  output logic          mdc,
  output logic          mdio_o,
  output logic          mdio_oe,
  input  logic          mdio_i
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

`ifdef MDIO_SHORT_PREAMBLE_EN
  localparam logic [5:0] FirstBit = 6'd32;
`else
  localparam logic [5:0] FirstBit = 6'd0;
`endif
  localparam logic [7:0] CntMax = 8'(MDC_DIV - 1);

  state_e      state_q, state_d;
  logic [5:0]  bit_q, bit_d;       // frame bit index k
  logic [7:0]  cnt_q, cnt_d;       // position within the current MDC half-period
  logic        mdc_q, mdc_d;       // also the MDC half-period phase
  logic        mdio_o_q, mdio_o_d;
  logic        oe_q, oe_d;
  logic [31:0] frame_q, frame_d;   // ST..DATA; preamble is generated, not stored
  logic        wr_q, wr_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [15:0] rx_q, rx_d;
  logic        ta_err_q, ta_err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_err_q, rd_err_d;
  logic        grant;
  logic        gnt_id;

  // Bits below 32 are preamble; bit k >= 32 maps to frame_q[63-k].
  function automatic logic frame_bit(logic [31:0] f, logic [5:0] k);
    logic [4:0] idx;
    idx = 5'd31 - k[4:0];
    return k[5] ? f[idx] : 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    mdc_d    = mdc_q;
    frame_d  = frame_q;
    wr_d     = wr_q;
    id_d     = id_q;
    last_d   = last_q;
    rx_d     = rx_q;
    ta_err_d = ta_err_q;
    rdata_d  = rdata_q;
    rd_err_d = rd_err_q;
    grant    = 1'b0;
    gnt_id   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          grant    = 1'b1;
          // On a tie the requester not served last wins; otherwise the sole one.
          gnt_id   = (&bus.req) ? ~last_q : bus.req[1];
          state_d  = StShift;
          bit_d    = FirstBit;
          cnt_d    = 8'd0;
          mdc_d    = 1'b0;
          id_d     = gnt_id;
          last_d   = gnt_id;
          wr_d     = bus.req_wr[gnt_id];
          ta_err_d = 1'b0;
          rx_d     = 16'h0000;
          frame_d  = {2'b01,
                      wr_d ? 2'b01 : 2'b10,
                      gnt_id ? bus.req_phy[9:5] : bus.req_phy[4:0],
                      gnt_id ? bus.req_reg[9:5] : bus.req_reg[4:0],
                      wr_d ? 2'b10 : 2'b11,
                      wr_d ? (gnt_id ? bus.req_wdata[31:16] : bus.req_wdata[15:0]) : 16'h0000};
        end
      end
      StShift: begin
        // First cycle with mdc high is the MDC rising edge: sample the PHY.
        if (mdc_q && cnt_q == 8'd0) begin
          if (bit_q == 6'd47) ta_err_d = mdio_i;
          if (bit_q >= 6'd48) rx_d = {rx_q[14:0], mdio_i};
        end
        if (cnt_q == CntMax) begin
          cnt_d = 8'd0;
          if (!mdc_q) begin
            mdc_d = 1'b1;
          end else begin
            mdc_d = 1'b0;
            if (bit_q == 6'd63) begin
              state_d = StDone;
              if (wr_q) begin
                rd_err_d = 1'b0;
              end else begin
                rdata_d  = rx_d;
                rd_err_d = ta_err_d;
              end
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin drivers are registered from next state so they change cleanly with mdc.
  assign mdio_o_d = (state_d == StShift) ? frame_bit(frame_d, bit_d) : 1'b0;
  assign oe_d     = (state_d == StShift) && (wr_d || bit_d <= 6'd45);

  always_ff @(posedge clk_200_mhz) begin
    if (rst) begin
      state_q  <= StIdle;
      bit_q    <= 6'd0;
      cnt_q    <= 8'd0;
      mdc_q    <= 1'b0;
      mdio_o_q <= 1'b0;
      oe_q     <= 1'b0;
      frame_q  <= 32'h0;
      wr_q     <= 1'b0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      rx_q     <= 16'h0000;
      ta_err_q <= 1'b0;
      rdata_q  <= 16'h0000;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      mdc_q    <= mdc_d;
      mdio_o_q <= mdio_o_d;
      oe_q     <= oe_d;
      frame_q  <= frame_d;
      wr_q     <= wr_d;
      id_q     <= id_d;
      last_q   <= last_d;
      rx_q     <= rx_d;
      ta_err_q <= ta_err_d;
      rdata_q  <= rdata_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign mdc         = mdc_q;
  assign mdio_o      = mdio_o_q;
  assign mdio_oe     = oe_q;
  assign bus.ack     = (grant && !rst) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy    = (state_q != StIdle) || (grant && !rst);
  assign bus.done    = (state_q == StDone);
  assign bus.done_id = id_q;
  assign bus.rdata   = rdata_q;
  assign bus.rd_err  = rd_err_q;

endmodule

// File: tb/tb_mdio_master.sv
module tb_mdio_master;
  localparam int unsigned DIV = 4;
`ifdef MDIO_SHORT_PREAMBLE_EN
  localparam int BASE = 32;
  localparam logic [63:0] LEN_MASK = 64'h0000_0000_FFFF_FFFF;
`else
  localparam int BASE = 0;
  localparam logic [63:0] LEN_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
  localparam int NBITS = 64 - BASE;
  localparam int FRAME_CYC = 1 + 2 * DIV * NBITS;
  localparam logic [63:0] RD_OE_MASK = {{46{1'b1}}, 18'h0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;

  mdio_master_if bus();

  mdio_master #(.MDC_DIV(DIV)) dut (
    .clk_200_mhz(clk),
    .rst        (rst),
    .bus        (bus),
    .mdc        (mdc),
    .mdio_o     (mdio_o),
    .mdio_oe    (mdio_oe),
    .mdio_i     (mdio_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor / PHY model state
  int          cyc = 0;
  int          cap_n = 0;
  logic [63:0] cap_o = '0, cap_oe = '0;
  int          done_cnt = 0, ack_cyc = 0, done_cyc = 0;
  int          ack_id_q[$], ack_cyc_q[$], done_cyc_q[$];
  logic        d_id, d_err, d_mdc, d_oe, d_busy;
  logic [15:0] d_rdata;
  logic        mdc_prev = 1'b0;
  logic        phy_resp = 1'b0;
  logic [15:0] phy_data = '0;
  logic [15:0] rdata_m = '0;

  function automatic logic phy_val(int k);
    if (!phy_resp) return 1'b1;  // pull-up only
    if (k == 47) return 1'b0;
    if (k >= 48 && k <= 63) return phy_data[63 - k];
    return 1'b1;
  endfunction

  function automatic logic [63:0] exp_frame(logic wr, logic [4:0] phy, logic [4:0] rg,
                                            logic [15:0] wd);
    return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, wd};
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (|bus.ack) begin
      ack_cyc = cyc;
      ack_id_q.push_back(bus.ack[1] ? 1 : 0);
      ack_cyc_q.push_back(cyc);
      cap_n = 0;
      cap_o = '0;
      cap_oe = '0;
      mdio_i = 1'b1;
    end
    if (mdc && !mdc_prev && cap_n < NBITS) begin
      cap_o[63 - (BASE + cap_n)] = mdio_o;
      cap_oe[63 - (BASE + cap_n)] = mdio_oe;
      cap_n = cap_n + 1;
    end
    // PHY changes its output after the MDC falling edge, for the next bit.
    if (!mdc && mdc_prev) mdio_i = phy_val(BASE + cap_n);
    if (bus.done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_cyc_q.push_back(cyc);
      d_id = bus.done_id;
      d_err = bus.rd_err;
      d_rdata = bus.rdata;
      d_mdc = mdc;
      d_oe = mdio_oe;
      d_busy = bus.busy;
    end
    mdc_prev = mdc;
  end

  task automatic run_one(input int id, input logic wr, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd, output logic timeout);
    int n;
    int dc0;
    timeout = 1'b0;
    dc0 = done_cnt;
    @(posedge clk); #1;
    bus.req = '0;
    bus.req[id] = 1'b1;
    bus.req_wr[id] = wr;
    bus.req_phy[5*id +: 5] = phy;
    bus.req_reg[5*id +: 5] = rg;
    bus.req_wdata[16*id +: 16] = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack[id] && n < 20);
    if (!bus.ack[id]) begin timeout = 1'b1; bus.req = '0; return; end
    @(posedge clk); #1;
    bus.req = '0;
    // Fields are don't-care after ack: scramble them.
    bus.req_wr = 2'($urandom);
    bus.req_phy = 10'($urandom);
    bus.req_reg = 10'($urandom);
    bus.req_wdata = $urandom;
    n = 0;
    while (done_cnt == dc0 && n < FRAME_CYC + 20) begin @(posedge clk); n++; end
    if (done_cnt == dc0) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({mdc, mdio_o, mdio_oe} !== 3'b000) begin failures++;
      $display("FAIL reset_pins got=%b exp=000", {mdc, mdio_o, mdio_oe}); end
    checks++; if ({bus.ack, bus.done, bus.busy} !== 4'b0000) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus.ack, bus.done, bus.busy}); end
    checks++; if ({bus.done_id, bus.rd_err, bus.rdata} !== 18'h0) begin failures++;
      $display("FAIL reset_result got=%h exp=0", {bus.done_id, bus.rd_err, bus.rdata}); end
    rdata_m = 16'h0000;
  endtask

  task automatic test_write();
    logic to;
    phy_resp = 1'b0;
    run_one(0, 1'b1, 5'd1, 5'd0, 16'h3100, to);
    checks++;
    if (to) begin failures++; $display("FAIL write_timeout got=timeout exp=done"); end
    else begin
      if ((cap_o & LEN_MASK) !== (64'hFFFF_FFFF_5082_3100 & LEN_MASK)) begin failures++;
        $display("FAIL write_frame got=%h exp=%h", cap_o & LEN_MASK,
                 64'hFFFF_FFFF_5082_3100 & LEN_MASK); end
      checks++; if (cap_oe !== LEN_MASK) begin failures++;
        $display("FAIL write_oe got=%h exp=%h", cap_oe, LEN_MASK); end
      checks++; if (done_cyc - ack_cyc !== FRAME_CYC) begin failures++;
        $display("FAIL write_latency got=%0d exp=%0d", done_cyc - ack_cyc, FRAME_CYC); end
      checks++; if (d_id !== 1'b0 || d_err !== 1'b0 || d_rdata !== rdata_m) begin failures++;
        $display("FAIL write_result got=%b/%b/%h exp=0/0/%h", d_id, d_err, d_rdata, rdata_m); end
      checks++; if ({d_mdc, d_oe, d_busy} !== 3'b001) begin failures++;
        $display("FAIL write_done_pins got=%b exp=001", {d_mdc, d_oe, d_busy}); end
    end
  endtask

  task automatic test_read();
    logic to;
    phy_resp = 1'b1;
    phy_data = 16'h0007;
    run_one(1, 1'b0, 5'd1, 5'd2, 16'hBEEF, to);
    checks++;
    if (to) begin failures++; $display("FAIL read_timeout got=timeout exp=done"); end
    else begin
      if ((cap_o & LEN_MASK & RD_OE_MASK) !==
          (exp_frame(1'b0, 5'd1, 5'd2, 16'h0) & LEN_MASK & RD_OE_MASK)) begin failures++;
        $display("FAIL read_frame got=%h exp=%h", cap_o & LEN_MASK & RD_OE_MASK,
                 exp_frame(1'b0, 5'd1, 5'd2, 16'h0) & LEN_MASK & RD_OE_MASK); end
      checks++; if (cap_oe !== (LEN_MASK & RD_OE_MASK)) begin failures++;
        $display("FAIL read_oe got=%h exp=%h", cap_oe, LEN_MASK & RD_OE_MASK); end
      checks++; if (d_rdata !== 16'h0007 || d_err !== 1'b0 || d_id !== 1'b1) begin failures++;
        $display("FAIL read_result got=%h/%b/%b exp=0007/0/1", d_rdata, d_err, d_id); end
      rdata_m = 16'h0007;
    end
  endtask

  task automatic test_no_phy();
    logic to;
    phy_resp = 1'b0;
    run_one(0, 1'b0, 5'd3, 5'd1, 16'h0, to);
    checks++;
    if (to) begin failures++; $display("FAIL nophy_timeout got=timeout exp=done"); end
    else if (d_err !== 1'b1 || d_rdata !== 16'hFFFF) begin failures++;
      $display("FAIL nophy_result got=%b/%h exp=1/ffff", d_err, d_rdata); end
    rdata_m = 16'hFFFF;
  endtask

  task automatic test_random();
    logic to;
    for (int i = 0; i < 8; i++) begin
      int id;
      logic wr;
      logic [4:0] phy, rg;
      logic [15:0] wd, er;
      logic [63:0] m;
      id = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      phy = 5'($urandom);
      rg = 5'($urandom);
      wd = 16'($urandom);
      phy_resp = ($urandom_range(0, 3) != 0);
      phy_data = 16'($urandom);
      run_one(id, wr, phy, rg, wd, to);
      checks++;
      if (to) begin failures++; $display("FAIL rand%0d_timeout got=timeout exp=done", i); end
      else begin
        m = wr ? LEN_MASK : (LEN_MASK & RD_OE_MASK);
        er = wr ? rdata_m : (phy_resp ? phy_data : 16'hFFFF);
        if ((cap_o & m) !== (exp_frame(wr, phy, rg, wd) & m)) begin failures++;
          $display("FAIL rand%0d_frame got=%h exp=%h", i, cap_o & m,
                   exp_frame(wr, phy, rg, wd) & m); end
        checks++; if (cap_oe !== m) begin failures++;
          $display("FAIL rand%0d_oe got=%h exp=%h", i, cap_oe, m); end
        checks++; if (done_cyc - ack_cyc !== FRAME_CYC) begin failures++;
          $display("FAIL rand%0d_latency got=%0d exp=%0d", i, done_cyc - ack_cyc, FRAME_CYC); end
        checks++;
        if (d_id !== 1'(id) || d_rdata !== er || d_err !== (!wr && !phy_resp)) begin failures++;
          $display("FAIL rand%0d_result got=%b/%h/%b exp=%0d/%h/%b", i, d_id, d_rdata, d_err,
                   id, er, (!wr && !phy_resp)); end
        rdata_m = er;
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    int dc0;
    logic last_m;
    int exp_id;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rdata_m = 16'h0000;
    phy_resp = 1'b0;
    ack_id_q.delete(); ack_cyc_q.delete(); done_cyc_q.delete();
    dc0 = done_cnt;
    bus.req_wr = 2'b11;
    bus.req_phy = 10'($urandom);
    bus.req_reg = 10'($urandom);
    bus.req_wdata = $urandom;
    bus.req = 2'b11;
    n = 0;
    while (done_cnt - dc0 < 4 && n < 4 * (FRAME_CYC + 10)) begin @(posedge clk); n++; end
    #1 bus.req = 2'b00;
    repeat (3) @(posedge clk);
    checks++;
    if (ack_id_q.size() != 4 || done_cyc_q.size() != 4) begin failures++;
      $display("FAIL rr_count got=%0d/%0d exp=4/4", ack_id_q.size(), done_cyc_q.size()); end
    else begin
      last_m = 1'b1;
      for (int i = 0; i < 4; i++) begin
        exp_id = last_m ? 0 : 1;
        last_m = 1'(exp_id);
        checks++; if (ack_id_q[i] != exp_id) begin failures++;
          $display("FAIL rr_grant%0d got=%0d exp=%0d", i, ack_id_q[i], exp_id); end
        if (i > 0) begin
          checks++; if (ack_cyc_q[i] != done_cyc_q[i-1] + 1) begin failures++;
            $display("FAIL rr_gap%0d got=%0d exp=%0d", i, ack_cyc_q[i], done_cyc_q[i-1] + 1); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic to;
    int n;
    int dc0;
    phy_resp = 1'b0;
    @(posedge clk); #1;
    bus.req_wr[1] = 1'b1;
    bus.req_phy[9:5] = 5'd4;
    bus.req_reg[9:5] = 5'd9;
    bus.req_wdata[31:16] = 16'hA5A5;
    bus.req = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack[1] && n < 20);
    @(posedge clk); #1 bus.req = 2'b00;
    n = 0;
    while (cap_n < 21 - BASE && n < FRAME_CYC) begin @(posedge clk); n++; end
    dc0 = done_cnt;
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({mdc, mdio_oe, bus.busy} !== 3'b000) begin failures++;
      $display("FAIL abort_pins got=%b exp=000", {mdc, mdio_oe, bus.busy}); end
    repeat (FRAME_CYC + 10) @(posedge clk);
    checks++; if (done_cnt != dc0) begin failures++;
      $display("FAIL abort_done got=%0d exp=%0d", done_cnt, dc0); end
    rdata_m = 16'h0000;
    run_one(0, 1'b1, 5'd7, 5'd17, 16'h1234, to);
    checks++;
    if (to) begin failures++; $display("FAIL abort_next_timeout got=timeout exp=done"); end
    else begin
      if ((cap_o & LEN_MASK) !== (exp_frame(1'b1, 5'd7, 5'd17, 16'h1234) & LEN_MASK)) begin
        failures++;
        $display("FAIL abort_next_frame got=%h exp=%h", cap_o & LEN_MASK,
                 exp_frame(1'b1, 5'd7, 5'd17, 16'h1234) & LEN_MASK); end
      checks++; if (done_cyc - ack_cyc !== FRAME_CYC || d_rdata !== rdata_m) begin failures++;
        $display("FAIL abort_next_done got=%0d/%h exp=%0d/%h", done_cyc - ack_cyc, d_rdata,
                 FRAME_CYC, rdata_m); end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_wr = '0;
    bus.req_phy = '0;
    bus.req_reg = '0;
    bus.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_no_phy();
    test_random();
    test_round_robin();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
